kbest_readout: RTL and testbench

//  Read-side drain engine for the k-best index arrays. After a search pass, sweeps

---
 rtl/kbest_readout.sv | 128 ++++++++++++
 tb/tb_kbest_readout.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/kbest_readout.sv
// Drains the k-best index arrays through read port 1 and streams each patch's 2K entries out over valid/ready.
// Optional KBEST_READOUT_PREFETCH_EN: a shadow buffer prefetches the next patch so SEND runs without bubbles.
module kbest_readout #(
    parameter int IDX_WIDTH   = 9,
    parameter int K           = 4,
    parameter int NUM_LEAVES  = 64,
    parameter int LEAF_ADDRW  = $clog2(NUM_LEAVES),
    parameter int NUM_PATCHES = 512,
    localparam int EW         = LEAF_ADDRW + IDX_WIDTH,
    localparam int KW         = (K > 1) ? $clog2(K) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [K-1:0]          csb1,
    output logic [8:0]            addr1,
    input  logic [K-1:0][EW-1:0]  ridx0_in,
    input  logic [K-1:0][EW-1:0]  ridx1_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EW-1:0]         out_data,
    output logic [8:0]            out_patch,
    output logic                  out_unit,
    output logic [KW-1:0]         out_k,
    output logic                  out_last
);
    localparam int NW  = 2 * K;
    localparam int WCW = $clog2(NW);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_CAPT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]                state;
    logic [NW-1:0][EW-1:0]     bufr;   // [K-1:0] unit0, [2K-1:K] unit1
    logic [8:0]                patch;
    logic [WCW-1:0]            wcnt;
    logic [WCW-1:0]            kfull;
    logic                      xfer, last_word, last_patch, rd, unit;

    assign last_word  = (wcnt == WCW'(NW - 1));
    assign last_patch = (patch == 9'(NUM_PATCHES - 1));
    assign out_valid  = (state == S_SEND);
    assign xfer       = out_valid && out_ready;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign unit       = (wcnt >= WCW'(K));
    assign kfull      = unit ? wcnt - WCW'(K) : wcnt;

    // Stream fields are forced to zero whenever no word is being offered.
    assign out_data   = out_valid ? bufr[wcnt] : '0;
    assign out_patch  = out_valid ? patch : '0;
    assign out_unit   = out_valid && unit;
    assign out_k      = out_valid ? KW'(kfull) : '0;
    assign out_last   = out_valid && last_word && last_patch;
    assign csb1       = {K{~rd}};

`ifdef KBEST_READOUT_PREFETCH_EN
    logic [NW-1:0][EW-1:0] shadow;
    logic                  pf_issue, pf_capt, pf_issued;

    // One prefetch per patch, on its first SEND cycle, never past the last patch.
    assign pf_issue = (state == S_SEND) && !pf_issued && !last_patch;
    assign rd       = (state == S_READ) || pf_issue;
    assign addr1    = (state == S_READ) ? patch :
                      pf_issue          ? patch + 9'd1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            pf_capt   <= 1'b0;
            pf_issued <= 1'b0;
        end else begin
            pf_capt <= pf_issue;
            if (pf_capt) shadow <= {ridx1_in, ridx0_in};
            if (state != S_SEND || (xfer && last_word)) pf_issued <= 1'b0;
            else if (pf_issue)                          pf_issued <= 1'b1;
        end
    end
`else
    assign rd    = (state == S_READ);
    assign addr1 = rd ? patch : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            bufr  <= '0;
            patch <= '0;
            wcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_READ;
                    patch <= '0;
                    wcnt  <= '0;
                end
                S_READ: state <= S_CAPT;
                S_CAPT: begin
                    bufr  <= {ridx1_in, ridx0_in};
                    state <= S_SEND;
                end
                S_SEND: if (xfer) begin
                    if (!last_word) begin
                        wcnt <= wcnt + 1'b1;
                    end else if (last_patch) begin
                        state <= S_DONE;
                    end else begin
                        patch <= patch + 9'd1;
                        wcnt  <= '0;
`ifdef KBEST_READOUT_PREFETCH_EN
                        // With K=1 the prefetch data may still be on the read bus.
                        bufr  <= pf_capt ? {ridx1_in, ridx0_in} : shadow;
`else
                        state <= S_READ;
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kbest_readout.sv
// Scoreboard bench for kbest_readout: default-size drain (reset, full, backpressure, start drops)
// plus a NUM_PATCHES=1, K=1 instance for the boundary case.
module tb_kbest_readout;
    localparam int EW = 15, K = 4, NP = 512, LIMIT = 40000;

    typedef struct packed {
        logic [EW-1:0] data;
        logic [8:0]    patch;
        logic          unit;
        logic [1:0]    k;
        logic          last;
    } exp_t;

    logic clk = 0, rst = 1, start = 0, out_ready = 1, bp_mode = 0;
    logic busy, done, out_valid, out_unit, out_last;
    logic [K-1:0] csb1;
    logic [8:0] addr1, out_patch;
    logic [K-1:0][EW-1:0] r0, r1;
    logic [EW-1:0] out_data;
    logic [1:0] out_k;

    logic start2 = 0, busy2, done2, csb1_2, out_valid2, out_unit2, out_k2, out_last2;
    logic [8:0] addr1_2, out_patch2;
    logic [0:0][EW-1:0] r0_2, r1_2;
    logic [EW-1:0] out_data2;

    int tests = 0, fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    kbest_readout dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .csb1(csb1), .addr1(addr1), .ridx0_in(r0), .ridx1_in(r1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_patch(out_patch), .out_unit(out_unit), .out_k(out_k), .out_last(out_last)
    );

    kbest_readout #(.K(1), .NUM_PATCHES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .csb1(csb1_2), .addr1(addr1_2), .ridx0_in(r0_2), .ridx1_in(r1_2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .out_patch(out_patch2), .out_unit(out_unit2), .out_k(out_k2), .out_last(out_last2)
    );

    // SRAM models: 1-cycle read latency, X on the bus outside read-data cycles.
    always @(posedge clk) begin
        for (int k = 0; k < K; k++) begin
            r0[k] <= (csb1 == '0) ? EW'(addr1 + k) : 'x;
            r1[k] <= (csb1 == '0) ? EW'(addr1 + k + 16) : 'x;
        end
        r0_2[0] <= (csb1_2 == 1'b0) ? EW'(addr1_2) : 'x;
        r1_2[0] <= (csb1_2 == 1'b0) ? EW'(addr1_2 + 16) : 'x;
    end

    always begin
        @(posedge clk);
        #2 out_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks hold-while-stalled and read port.
    int tick = 0, last_tick = -10, ndone = 0, rdcnt = 0, viol = 0;
    logic [8:0] exp_addr = 0;
    logic pv = 0, pr = 0;
    exp_t pw, cur, e;
    always @(posedge clk) tick++;
    always @(negedge clk) begin
        if (rst) pv = 0;
        else begin
            cur = {out_data, out_patch, out_unit, out_k, out_last};
            if (pv && !pr) chk("stall_hold", {out_valid, cur}, {1'b1, pw});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_word: got %0h expected none", cur);
                end else begin
                    e = q.pop_front();
                    chk("word", cur, e);
                    if ($isunknown(out_data)) chk("x_data", 1, 0);
                end
                last_tick = tick;
            end
            pv = out_valid; pr = out_ready; pw = cur;
            if (done) begin
                ndone++;
                chk("done_after_last", tick, last_tick + 1);
            end
            if (csb1 !== '1) begin
                if (csb1 !== '0 || addr1 !== exp_addr) viol++;
                exp_addr++;
                rdcnt++;
            end
        end
    end

    task automatic push_exp();
        for (int a = 0; a < NP; a++)
            for (int u = 0; u < 2; u++)
                for (int k = 0; k < K; k++)
                    q.push_back({EW'(a + k + 16 * u), 9'(a), 1'(u), 2'(k),
                                 1'(a == NP - 1 && u == 1 && k == K - 1)});
    endtask

    task automatic drain(input bit bp, input bit inj, output int cyc);
        int d0;
        bit did = 0;
        rdcnt = 0; exp_addr = 0; viol = 0; d0 = ndone;
        push_exp();
        bp_mode = bp;
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        cyc = 0;
        while (cyc < LIMIT) begin
            @(posedge clk); #1 cyc++;
            start = 0;
            if (inj && !did && out_patch == 9'd100) begin start = 1; did = 1; end
            if (done) break;
        end
        if (cyc >= LIMIT) chk("drain_timeout", cyc, 0);
        if (inj) begin
            start = 1;                      // pulse inside the done cycle
            @(posedge clk); #1 start = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        bp_mode = 0;
        chk("drained", q.size(), 0);
        chk("reads", rdcnt, NP);
        chk("csb_addr_viol", viol, 0);
        chk("done_pulses", ndone - d0, 1);
        chk("idle_after", busy, 0);
    endtask

    int cyc, nw, rd2, nd2;
    logic [8:0] maxa;
    bit found;
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_csb1", csb1, 4'hF);
        chk("rst_addr1", addr1, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk) rst = 0;

        // Reset mid-SEND at patch 37.
        push_exp();
        @(negedge clk) start = 1;
        @(posedge clk); #1 start = 0;
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(negedge clk);
            if (out_valid && out_patch == 9'd37) found = 1;
        end
        chk("reach_p37", found, 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_csb1", csb1, 4'hF);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_patch", out_patch, 0);
        q.delete();
        @(posedge clk); #1;
        chk("mid_rst_valid2", out_valid, 0);
        chk("mid_rst_csb1_2", csb1, 4'hF);
        chk("mid_rst_busy2", busy, 0);
        @(negedge clk) rst = 0;

        // Full drain from patch 0 with out_ready=1, cycle budget checked.
        drain(0, 0, cyc);
`ifdef KBEST_READOUT_PREFETCH_EN
        chk("drain_cycles", cyc, 2 + NP * 2 * K);
`else
        chk("drain_cycles", cyc, NP * (2 * K + 2));
`endif

        // Backpressure plus dropped start pulses.
        drain(1, 1, cyc);

        // Boundary instance: one patch, K=1.
        @(negedge clk) start2 = 1;
        @(posedge clk); #1 start2 = 0;
        nw = 0; rd2 = 0; nd2 = 0; maxa = 0;
        repeat (20) begin
            if (out_valid2) begin
                case (nw)
                    0: chk("k1_w0", {out_data2, out_unit2, out_k2, out_last2}, {15'd0, 1'b0, 1'b0, 1'b0});
                    1: chk("k1_w1", {out_data2, out_unit2, out_k2, out_last2}, {15'd16, 1'b1, 1'b0, 1'b1});
                    default: chk("k1_extra", nw, 1);
                endcase
                nw++;
            end
            if (csb1_2 == 1'b0) begin
                rd2++;
                if (addr1_2 > maxa) maxa = addr1_2;
            end
            if (done2) nd2++;
            @(posedge clk); #1;
        end
        chk("k1_words", nw, 2);
        chk("k1_reads", rd2, 1);
        chk("k1_max_addr", maxa, 0);
        chk("k1_done", nd2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
